// File: rtl/rice_core_lsu.sv
// rice_core_lsu: single-outstanding load/store unit with local misalignment trap, lane steering and load extension.
module rice_core_lsu #(
  parameter int XLEN = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [4:0]               i_access,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [XLEN-1:0]          i_store_data,
  input  logic [4:0]               i_rd,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [4:0]               o_rd,
  output logic                     o_rd_write,
  output logic [XLEN-1:0]          o_load_data,
  output logic                     o_misaligned,
  output logic                     o_access_fault,
  output logic                     o_bus_request_valid,
  input  logic                     i_bus_request_ready,
  output logic                     o_bus_write,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [3:0]               o_bus_strobe,
  output logic [XLEN-1:0]          o_bus_write_data,
  input  logic                     i_bus_response_valid,
  output logic                     o_bus_response_ready,
  input  logic [XLEN-1:0]          i_bus_response_data,
  input  logic                     i_bus_response_error
);
  typedef enum logic [1:0] {IDLE, REQUEST, RESPONSE, DONE} state_t;
  localparam logic [1:0] ACC_STORE = 2'd1;
  localparam logic [1:0] ACC_LOAD  = 2'd2;
  state_t state;
  logic [1:0] acc_type;
  logic [2:0] acc_mode;
  logic [1:0] offset;
  logic [1:0] in_type;
  logic [2:0] in_mode;
  logic [1:0] in_off;
  logic mem_op, mode_legal, misaligned;
  logic [3:0] strobe;
  logic [XLEN-1:0] wdata;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  logic [XLEN-1:0] ext;
  logic load_ok;
  assign in_type = i_access[4:3];
  assign in_mode = i_access[2:0];
  assign in_off = i_address[1:0];
  assign mem_op = (in_type == ACC_STORE) || (in_type == ACC_LOAD);
  // legal modes are B, H, W, BU, HU; everything else traps as misaligned
  assign mode_legal = !(in_mode[1] && (in_mode[0] || in_mode[2]));
  assign misaligned = mem_op && (!mode_legal || (in_mode[1:0] == 2'b01 && in_off[0]) || (in_mode[1:0] == 2'b10 && in_off != 2'b00));
  assign strobe = in_mode[1] ? 4'b1111 : in_mode[0] ? 4'b0011 << in_off : 4'b0001 << in_off;
  assign wdata = in_mode[1] ? i_store_data : in_mode[0] ? {2{i_store_data[15:0]}} : {4{i_store_data[7:0]}};
  assign lane_b = i_bus_response_data[{offset, 3'b000} +: 8];
  assign lane_h = offset[1] ? i_bus_response_data[31:16] : i_bus_response_data[15:0];
  assign ext = acc_mode[1] ? i_bus_response_data :
               acc_mode[0] ? {{(XLEN-16){!acc_mode[2] && lane_h[15]}}, lane_h} :
               {{(XLEN-8){!acc_mode[2] && lane_b[7]}}, lane_b};
  assign load_ok = (acc_type == ACC_LOAD) && !i_bus_response_error;
  assign o_ready = state == IDLE;
  assign o_bus_request_valid = state == REQUEST;
  assign o_bus_response_ready = state == RESPONSE;
  assign o_valid = state == DONE;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      acc_type <= '0;
      acc_mode <= '0;
      offset <= '0;
      o_rd <= '0;
      o_rd_write <= 1'b0;
      o_load_data <= '0;
      o_misaligned <= 1'b0;
      o_access_fault <= 1'b0;
      o_bus_write <= 1'b0;
      o_bus_address <= '0;
      o_bus_strobe <= '0;
      o_bus_write_data <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          acc_type <= in_type;
          acc_mode <= in_mode;
          offset <= in_off;
          o_rd <= i_rd;
          o_rd_write <= 1'b0;
          o_load_data <= '0;
          o_misaligned <= misaligned;
          o_access_fault <= 1'b0;
          o_bus_write <= in_type == ACC_STORE;
          o_bus_address <= {i_address[ADDRESS_WIDTH-1:2], 2'b00};
          o_bus_strobe <= strobe;
          o_bus_write_data <= wdata;
          state <= (misaligned || !mem_op) ? DONE : REQUEST;
        end
        REQUEST: if (i_bus_request_ready) state <= RESPONSE;
        RESPONSE: if (i_bus_response_valid) begin
          o_access_fault <= i_bus_response_error;
          o_load_data <= load_ok ? ext : '0;
          o_rd_write <= load_ok && (o_rd != 5'd0);
          state <= DONE;
        end
        DONE: if (i_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/rice_core_lsu.md
# rice_core_lsu

Load/store unit of the rice core, sitting between execute and writeback. It accepts one memory operation at a time from execute: access type/mode, effective address from the ALU, rs2 store data and rd. It drives a request/response data bus, then aligns and sign/zero-extends load data before handing a result to writeback. Misaligned accesses are trapped locally and never reach the bus.

## Interface
- XLEN, 32, data width; only 32 is supported.
- ADDRESS_WIDTH, 32, byte address width.

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  operation from execute valid
- o_ready  out  1  LSU can accept an operation
- i_access  in  5  memory access descriptor: access_type[4:3] (NONE=0, STORE=1, LOAD=2), access_mode[2:0] (B=000, H=001, W=010, BU=100, HU=101)
- i_address  in  ADDRESS_WIDTH  effective byte address
- i_store_data  in  XLEN  rs2 value
- i_rd  in  5  destination register
- o_valid  out  1  result to writeback valid
- i_ready  in  1  writeback accepts result
- o_rd  out  5  destination register
- o_rd_write  out  1  result must be written to o_rd
- o_load_data  out  XLEN  aligned, extended load data
- o_misaligned  out  1  misaligned-access exception
- o_access_fault  out  1  bus error exception
- o_bus_request_valid  out  1  bus request valid
- i_bus_request_ready  in  1  bus accepts request
- o_bus_write  out  1  1=store, 0=load
- o_bus_address  out  ADDRESS_WIDTH  word-aligned address; bits [1:0] are 0
- o_bus_strobe  out  4  byte enables
- o_bus_write_data  out  XLEN  lane-replicated store data
- i_bus_response_valid  in  1  response valid
- o_bus_response_ready  out  1  LSU accepts response
- i_bus_response_data  in  XLEN  read data (full word)
- i_bus_response_error  in  1  response carries an access error

## Operation
- FSM states: IDLE, REQUEST, RESPONSE, DONE.
- IDLE: o_ready=1. Accept on i_valid&&o_ready, registering access, address, store data and rd.
  - Misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) -> DONE with o_misaligned=1, o_rd_write=0.
  - access_type NONE -> DONE, o_rd_write=0.
  - Otherwise -> REQUEST.
  - Illegal access_mode with LOAD/STORE is treated as misaligned.
- REQUEST: o_bus_request_valid=1. Bus outputs are held stable until i_bus_request_ready. On ready -> RESPONSE.
- RESPONSE: o_bus_response_ready=1. On i_bus_response_valid, capture data and error -> DONE.
- DONE: o_valid=1. All result outputs are stable until i_ready. On i_ready -> IDLE.
- Strobe:
  - B/BU: 4'b0001<<addr[1:0]
  - H/HU: 4'b0011<<addr[1:0]
  - W: 4'b1111
  - Loads use the same strobes.
- Write data: B = {4{d[7:0]}}, H = {2{d[15:0]}}, W = d.
- Load extraction:
  - Byte lane addr[1:0], halfword lane addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes the word unchanged.
- Result fields:
  - o_rd_write = LOAD && !error && rd!=0.
  - On error, o_load_data=0. Stores always give o_load_data=0 and o_rd_write=0.
  - rd=0 loads still perform the bus access.
- i_bus_response_error sets o_access_fault=1. The response data is discarded.
- One outstanding transaction maximum. No new operation is accepted before DONE handshakes.

## Timing
- Reset values: state=IDLE; o_ready=1; all other outputs 0.
- Reset mid-transaction abandons the operation: request dropped, nothing delivered.
  - A response arriving after reset is not accepted (o_bus_response_ready=0).
- Output registering: o_bus_* request fields come from registered state and are valid in the cycle after acceptance. o_valid and result fields are registered.
- Best-case load/store latency: accept at cycle 0; request at cycle 1 (ready same cycle); response at cycle 2; o_valid at cycle 3.
- Misaligned/NONE: accept at cycle 0, o_valid at cycle 1.
- Bus stall: REQUEST and RESPONSE hold indefinitely. A response valid in the same cycle as request acceptance is not sampled; the response is accepted only from RESPONSE.
- Writeback stall: DONE holds with o_ready=0. Back-to-back ops: the next accept occurs no earlier than the cycle after the DONE handshake.

## Test plan
- LB at 0x1003, bus data 0x80_00_00_00 -> strobe 4'b1000, address 0x1000, o_load_data=0xFFFFFF80, o_rd_write=1; repeat LBU -> 0x00000080.
- SH at 0x2002, data 0x1234ABCD -> o_bus_write=1, strobe 4'b1100, write data 0xABCDABCD, o_rd_write=0.
- LW at 0x3001 -> no bus request for 10 cycles, o_valid at cycle 1, o_misaligned=1, o_load_data=0.
- LW with i_bus_request_ready low 3 cycles, response delayed 4 cycles, i_ready low 2 cycles -> bus outputs and result stable throughout, o_ready=0 until DONE handshake, exactly one result delivered.
- LH at 0x4000 with i_bus_response_error=1 -> o_access_fault=1, o_rd_write=0, o_load_data=0.
- Assert i_rst during RESPONSE, then a stray response -> all outputs return to reset values immediately, stray response not accepted, next LW completes normally.
